// File: rtl/pcie_mailbox_reader.sv
// Polls one mailbox word per core in shared RAM and hands fresh payloads, flagged by a toggling bit 31, to the addressed core.
// Read strobe 1 cycle after an enabled IDLE edge, core_valid 2 edges later; a pending payload is held until core_ready.
module pcie_mailbox_reader #(
    parameter int NUM_CORES = 1,
    parameter int CORE_ID_W = 1,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 ram_rd_en,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic [31:0]          ram_rd_data,
    output logic                 core_valid,
    output logic [CORE_ID_W-1:0] core_id,
    output logic [30:0]          core_data,
    input  logic                 core_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DELIVER} state_t;

    localparam logic [CORE_ID_W-1:0] LAST_PTR = CORE_ID_W'(NUM_CORES - 1);
    localparam logic [ADDR_W-1:0]    BASE     = ADDR_W'(BASE_ADDR);

    state_t                 state_q;
    logic [CORE_ID_W-1:0]   ptr_q;
    logic [CORE_ID_W-1:0]   ptr_d;
    logic [NUM_CORES-1:0]   lead_q;
    logic                   rd_en_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   valid_q;
    logic [CORE_ID_W-1:0]   id_q;
    logic [30:0]            data_q;

    always_comb begin
        ptr_d = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
    end

    // Lead bits reset to 1 so an all-zero RAM is always seen as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lead_q  <= '1;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        rd_en_q <= 1'b1;
                        addr_q  <= BASE + ADDR_W'(ptr_q);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rd_en_q <= 1'b0;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (ram_rd_data[31] == lead_q[ptr_q]) begin
                        data_q  <= ram_rd_data[30:0];
                        id_q    <= ptr_q;
                        valid_q <= 1'b1;
                        state_q <= DELIVER;
                    end else begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                DELIVER: begin
                    if (core_ready) begin
                        valid_q        <= 1'b0;
                        lead_q[ptr_q]  <= ~lead_q[ptr_q];
                        ptr_q          <= ptr_d;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_rd_en  = rd_en_q;
    assign ram_addr   = addr_q;
    assign core_valid = valid_q;
    assign core_id    = id_q;
    assign core_data  = data_q;

endmodule

// File: tb/tb_pcie_mailbox_reader.sv
// Directed bench: a single-core reader at address 0 and a four-core reader at base 16 share one RAM image.
module tb_pcie_mailbox_reader;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [0:1023];

    logic        en1, rd_en1, valid1, ready1;
    logic [9:0]  addr1;
    logic [31:0] rdata1;
    logic [0:0]  id1;
    logic [30:0] data1;

    logic        en4, rd_en4, valid4, ready4;
    logic [9:0]  addr4;
    logic [31:0] rdata4;
    logic [1:0]  id4;
    logic [30:0] data4;

    int checks;
    int errors;

    pcie_mailbox_reader #(.NUM_CORES(1), .CORE_ID_W(1), .ADDR_W(10), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1),
        .ram_rd_en(rd_en1), .ram_addr(addr1), .ram_rd_data(rdata1),
        .core_valid(valid1), .core_id(id1), .core_data(data1), .core_ready(ready1)
    );

    pcie_mailbox_reader #(.NUM_CORES(4), .CORE_ID_W(2), .ADDR_W(10), .BASE_ADDR(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4),
        .ram_rd_en(rd_en4), .ram_addr(addr4), .ram_rd_data(rdata4),
        .core_valid(valid4), .core_id(id4), .core_data(data4), .core_ready(ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en1) rdata1 <= mem[addr1];
        if (rd_en4) rdata4 <= mem[addr4];
    end

    task automatic wait_valid(input bit sel4, input int budget, output bit got, output int lat);
        int last;
        got  = 1'b0;
        lat  = -1;
        last = (sel4 ? rd_en4 : rd_en1) ? 0 : -1000;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (sel4 ? rd_en4 : rd_en1) last = c;
            if (sel4 ? valid4 : valid1) begin
                got = 1'b1;
                lat = c - last;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rd_en1 !== 1'b0) begin errors++; $display("FAIL reset_rd_en actual %0b required 0", rd_en1); end
        checks++; if (addr1 !== 10'd0) begin errors++; $display("FAIL reset_addr actual %0d required 0", addr1); end
        checks++; if (valid1 !== 1'b0 || valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid actual %0b%0b required 00", valid1, valid4); end
        checks++; if (id1 !== 1'd0 || id4 !== 2'd0) begin errors++; $display("FAIL reset_id actual %0d/%0d required 0/0", id1, id4); end
        checks++; if (data1 !== 31'd0 || data4 !== 31'd0) begin errors++; $display("FAIL reset_data actual %h/%h required 0/0", data1, data4); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_poll_idle();
        int last, pulses, vseen, badaddr;
        last = -1; pulses = 0; vseen = 0; badaddr = 0;
        en1 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rd_en1) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 3) begin errors++; $display("FAIL poll_period actual %0d required 3", c - last); end
                end
                if (addr1 !== 10'd0) badaddr++;
                last = c;
                pulses++;
            end
            if (valid1) vseen++;
        end
        checks++; if (pulses !== 17) begin errors++; $display("FAIL poll_pulses actual %0d required 17", pulses); end
        checks++; if (badaddr !== 0) begin errors++; $display("FAIL poll_addr nonzero_count %0d required 0", badaddr); end
        checks++; if (vseen !== 0) begin errors++; $display("FAIL poll_no_valid actual %0d required 0", vseen); end
    endtask

    task automatic test_hit_single();
        bit got; int lat, vseen;
        ready1 = 1'b1;
        mem[0] = 32'h8000_0ABC;
        wait_valid(1'b0, 20, got, lat);
        checks++; if (!got) begin errors++; $display("FAIL hit_valid actual timeout required valid"); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency actual %0d required 2", lat); end
        checks++; if (data1 !== 31'h0ABC) begin errors++; $display("FAIL hit_data actual %h required 0abc", data1); end
        checks++; if (id1 !== 1'd0) begin errors++; $display("FAIL hit_id actual %0d required 0", id1); end
        @(negedge clk);
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL hit_release actual %0b required 0", valid1); end
        vseen = 0;
        repeat (30) begin @(negedge clk); if (valid1) vseen++; end
        checks++; if (vseen !== 0) begin errors++; $display("FAIL no_redeliver actual %0d required 0", vseen); end
        mem[0] = 32'h0000_0123;
        wait_valid(1'b0, 20, got, lat);
        checks++; if (!got || data1 !== 31'h123) begin errors++; $display("FAIL toggle_hit actual got=%0b data=%h required got=1 data=123", got, data1); end
        mem[0] = 32'h0000_0124;
        @(negedge clk);
        vseen = 0;
        repeat (30) begin @(negedge clk); if (valid1) vseen++; end
        checks++; if (vseen !== 0) begin errors++; $display("FAIL same_lead_ignored actual %0d required 0", vseen); end
        en1 = 1'b0;
    endtask

    task automatic test_multi_core();
        int q[$];
        int vcount, c;
        bit got;
        ready4 = 1'b1;
        mem[18] = 32'h8000_0007;
        en4 = 1'b1;
        got = 1'b0;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_en4) q.push_back(int'(addr4));
            if (valid4) begin got = 1'b1; break; end
        end
        checks++; if (!got || q.size() !== 3) begin errors++; $display("FAIL multi_valid actual got=%0b polls=%0d required got=1 polls=3", got, q.size()); end
        checks++; if (q.size() < 3 || q[0] !== 16 || q[1] !== 17 || q[2] !== 18) begin errors++; $display("FAIL multi_addr_seq actual %p required 16 17 18", q); end
        checks++; if (id4 !== 2'd2 || data4 !== 31'd7) begin errors++; $display("FAIL multi_payload actual id=%0d data=%h required id=2 data=7", id4, data4); end
        q.delete();
        vcount = 0;
        for (c = 0; c < 30 && q.size() < 3; c++) begin
            @(negedge clk);
            if (rd_en4) q.push_back(int'(addr4));
            if (valid4) vcount++;
        end
        checks++; if (q.size() < 3 || q[0] !== 19 || q[1] !== 16 || q[2] !== 17) begin errors++; $display("FAIL multi_wrap actual %p required 19 16 17", q); end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL multi_silent actual %0d required 0", vcount); end
    endtask

    task automatic test_ready_hold();
        bit got; int lat, unstable;
        ready4 = 1'b0;
        mem[19] = 32'h8000_0033;
        wait_valid(1'b1, 20, got, lat);
        checks++; if (!got || id4 !== 2'd3 || data4 !== 31'h33) begin errors++; $display("FAIL hold_hit actual got=%0b id=%0d data=%h required got=1 id=3 data=33", got, id4, data4); end
        unstable = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid4 !== 1'b1 || id4 !== 2'd3 || data4 !== 31'h33) unstable++;
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL hold_stable bad_cycles %0d required 0", unstable); end
        ready4 = 1'b1;
        @(negedge clk);
        checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL hold_handshake actual %0b required 0", valid4); end
        @(negedge clk);
        checks++; if (rd_en4 !== 1'b1 || addr4 !== 10'd16) begin errors++; $display("FAIL hold_next_core actual en=%0b addr=%0d required en=1 addr=16", rd_en4, addr4); end
        en4 = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit got; int lat, strobes;
        ready1 = 1'b1;
        en1 = 1'b1;
        mem[0] = 32'h8000_00AA;
        for (int c = 0; c < 10 && !rd_en1; c++) @(negedge clk);
        @(negedge clk);
        en1 = 1'b0;
        wait_valid(1'b0, 5, got, lat);
        checks++; if (!got || data1 !== 31'hAA) begin errors++; $display("FAIL drop_delivery actual got=%0b data=%h required got=1 data=aa", got, data1); end
        strobes = 0;
        repeat (15) begin @(negedge clk); if (rd_en1) strobes++; end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL drop_stops_poll actual %0d required 0", strobes); end
        en1 = 1'b1;
        @(negedge clk);
        checks++; if (rd_en1 !== 1'b1) begin errors++; $display("FAIL drop_resume actual %0b required 1", rd_en1); end
    endtask

    task automatic test_reset_mid();
        bit got; int lat, vseen;
        ready1 = 1'b0;
        mem[0] = 32'h0000_0077;
        wait_valid(1'b0, 12, got, lat);
        checks++; if (!got || data1 !== 31'h77) begin errors++; $display("FAIL rst_pre_hit actual got=%0b data=%h required got=1 data=77", got, data1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid1 !== 1'b0 || data1 !== 31'd0) begin errors++; $display("FAIL rst_async actual valid=%0b data=%h required valid=0 data=0", valid1, data1); end
        #4 rst_n = 1'b1;
        ready1 = 1'b1;
        vseen = 0;
        repeat (20) begin @(negedge clk); if (valid1) vseen++; end
        checks++; if (vseen !== 0) begin errors++; $display("FAIL rst_lead0_ignored actual %0d required 0", vseen); end
        mem[0] = 32'h8000_0078;
        wait_valid(1'b0, 20, got, lat);
        checks++; if (!got || data1 !== 31'h78 || id1 !== 1'd0) begin errors++; $display("FAIL rst_lead1_hit actual got=%0b data=%h required got=1 data=78", got, data1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        en1 = 1'b0; ready1 = 1'b0;
        en4 = 1'b0; ready4 = 1'b0;
        test_reset();
        test_poll_idle();
        test_hit_single();
        test_multi_core();
        test_ready_hold();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_mailbox_reader.md
Name: pcie_mailbox_reader

Overview:
- Host-to-core companion of the core-to-host write stage in the PCIe control path.
- Polls one 32-bit mailbox word per simulated core in the PCIe-shared block RAM.
- Detects fresh host messages by a toggling lead bit (bit 31), the same sequence-flag convention the write stage uses toward the host.
- Delivers the 31-bit payload to the addressed core over a valid/ready handshake.

Parameters:
- NUM_CORES, 1, number of simulated cores; one mailbox word each.
- CORE_ID_W, 1, width of core_id; must be at least clog2(NUM_CORES), minimum 1.
- ADDR_W, 10, RAM word-address width.
- BASE_ADDR, 0, RAM word address of core 0's mailbox; core k is at BASE_ADDR+k.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  polling enable.
- ram_rd_en  out  1  RAM read strobe, registered.
- ram_addr  out  ADDR_W  RAM read address, registered.
- ram_rd_data  in  32  RAM read data, valid exactly 1 cycle after ram_rd_en.
- core_valid  out  1  payload available.
- core_id  out  CORE_ID_W  destination core of the payload.
- core_data  out  31  payload, from ram_rd_data[30:0].
- core_ready  in  1  consumer accepts the payload when high with core_valid.

Behaviour:
- Reset (async, rst_n=0):
  - ram_rd_en=0, ram_addr=0, core_valid=0, core_id=0, core_data=0.
  - Poll pointer ptr=0; state=IDLE.
  - expected_lead[k]=1 for every core, so an all-zero RAM never produces a delivery.
- States: IDLE, ISSUE, CHECK, DELIVER.
- IDLE:
  - If enable=1: next state ISSUE, with ram_rd_en<=1 and ram_addr<=BASE_ADDR+ptr registered on that edge.
  - If enable=0: stay in IDLE; ram_rd_en stays 0.
- ISSUE:
  - ram_rd_en<=0; next state CHECK. The RAM returns data during this cycle's successor.
- CHECK: sample ram_rd_data.
  - If ram_rd_data[31]==expected_lead[ptr]: core_data<=ram_rd_data[30:0], core_id<=ptr, core_valid<=1; next state DELIVER.
  - Otherwise (stale message): advance ptr; next state IDLE.
- DELIVER:
  - core_valid, core_id and core_data are held stable while core_ready=0.
  - On the edge where core_valid&core_ready=1: core_valid<=0, expected_lead[ptr] toggles, ptr advances; next state IDLE.
- Pointer advance: ptr+1, wrapping from NUM_CORES-1 to 0. With NUM_CORES=1, ptr stays 0.
- Latency:
  - Edge with enable=1 in IDLE → ram_rd_en high for the 1 following cycle.
  - core_valid rises 2 edges later on a hit.
  - Minimum poll period per core: 3 cycles (miss); a hit with immediate ready takes 4.
- enable deassertion:
  - Never aborts ISSUE, CHECK or DELIVER; a pending delivery completes normally.
  - Polling stops only on return to IDLE.
- core_ready outside DELIVER is ignored.
- The host updating a mailbox while it is being read is not detected. A word is consumed only by a hit in CHECK, so a message arriving after a miss is picked up on the next pass.
- Only one outstanding delivery at a time; no buffering beyond the output register.
- Reset mid-operation (any state): outputs and all expected_lead bits return to reset values immediately. The next message must carry lead bit 1.
- ram_addr arithmetic: BASE_ADDR+ptr computed at ADDR_W bits. Wrap above 2^ADDR_W is not checked; BASE_ADDR+NUM_CORES must fit in ADDR_W bits.

Test Plan:
1. Reset, RAM all zero, enable=1 for 50 cycles, NUM_CORES=1 → ram_rd_en pulses every 3 cycles at ram_addr=0; core_valid never asserts.
2. RAM[0]=0x8000_0ABC, core_ready=1 → core_valid high 2 edges after the read strobe with core_data=0x0000_0ABC, core_id=0. It is not redelivered on later polls. After RAM[0]=0x0000_0123 is written: delivered as 0x123. After a further write of 0x0000_0124: not delivered (lead bit matches the consumed value).
3. NUM_CORES=4, BASE_ADDR=16, RAM[18]=0x8000_0007 → ram_addr polls 16,17,18 and wraps 19→16; delivery to core_id=2 with data 7; other cores stay silent.
4. Hit with core_ready=0 for 10 cycles, then 1 → core_valid, core_id and core_data stable for all 10 cycles. Handshake completes on the first ready edge; polling resumes at the next core.
5. enable dropped during CHECK of a hit → delivery still occurs; afterwards ram_rd_en stays 0 until enable returns.
6. rst_n pulsed low during DELIVER (async, mid-cycle) → core_valid=0 immediately. After release, RAM[0] with lead bit 0 is not delivered; lead bit 1 is.
